// File: rtl/periph_req2apb_bridge_if.sv
// periph_req2apb_bridge_if
// Bundles the upstream valid/ready request/response channels and the APB3
// master signals of the request-to-APB bridge.
//   slave  : bridge view (accepts requests, drives APB, returns responses)
//   master : environment view (issues requests, plays the APB slave)
// Signals:
//   req_valid_i/req_ready_o/req_addr_i/req_we_i/req_wdata_i : request channel
//   rsp_valid_o/rsp_ready_i/rsp_rdata_o/rsp_err_o           : response channel
//   paddr_o/pwdata_o/pwrite_o/psel_o/penable_o               : APB request
//   prdata_i/pready_i/pslverr_i                              : APB completion
interface periph_req2apb_bridge_if #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32
) ();
    logic                      req_valid_i;
    logic                      req_ready_o;
    logic [APB_ADDR_WIDTH-1:0] req_addr_i;
    logic                      req_we_i;
    logic [APB_DATA_WIDTH-1:0] req_wdata_i;
    logic                      rsp_valid_o;
    logic                      rsp_ready_i;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_o;
    logic                      rsp_err_o;
    logic [APB_ADDR_WIDTH-1:0] paddr_o;
    logic [APB_DATA_WIDTH-1:0] pwdata_o;
    logic                      pwrite_o;
    logic                      psel_o;
    logic                      penable_o;
    logic [APB_DATA_WIDTH-1:0] prdata_i;
    logic                      pready_i;
    logic                      pslverr_i;

    modport slave (
        input  req_valid_i, req_addr_i, req_we_i, req_wdata_i, rsp_ready_i,
               prdata_i, pready_i, pslverr_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
               paddr_o, pwdata_o, pwrite_o, psel_o, penable_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_we_i, req_wdata_i, rsp_ready_i,
               prdata_i, pready_i, pslverr_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
               paddr_o, pwdata_o, pwrite_o, psel_o, penable_o
    );
endinterface

// File: rtl/periph_req2apb_bridge.sv
// periph_req2apb_bridge
// Turns one outstanding valid/ready request into a single APB3 transfer
// (SETUP then ACCESS) and returns read data / error on the response channel.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : periph_req2apb_bridge_if.slave (request, response and APB signals)
// Optional feature: define APB_BRIDGE_TIMEOUT_EN to end an ACCESS phase with an
// error response after TIMEOUT_CYCLES wait cycles without pready_i.
module periph_req2apb_bridge #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    periph_req2apb_bridge_if.slave bus
);
    localparam int unsigned AW = APB_ADDR_WIDTH;
    localparam int unsigned DW = APB_DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            we_q, we_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            req_ready_q;
    logic            rsp_valid_q;
    logic            psel_q;
    logic            penable_q;

`ifdef APB_BRIDGE_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    // Timeout limit has no effect in this build.
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

    // Next-state and next-register values.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef APB_BRIDGE_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // req_ready_q gates acceptance on the first cycle after reset.
                if (bus.req_valid_i && req_ready_q) begin
                    addr_d  = bus.req_addr_i;
                    we_d    = bus.req_we_i;
                    wdata_d = bus.req_we_i ? bus.req_wdata_i : '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
`ifdef APB_BRIDGE_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_ACCESS: begin
                if (bus.pready_i) begin
                    rdata_d = we_q ? '0 : bus.prdata_i;
                    err_d   = bus.pslverr_i;
                    state_d = ST_RESP;
                end
`ifdef APB_BRIDGE_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; handshake/APB strobes follow the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            req_ready_q <= (state_d == ST_IDLE);
            rsp_valid_q <= (state_d == ST_RESP);
            psel_q      <= (state_d == ST_SETUP) || (state_d == ST_ACCESS);
            penable_q   <= (state_d == ST_ACCESS);
        end
    end

`ifdef APB_BRIDGE_TIMEOUT_EN
    // ACCESS-phase wait counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign bus.req_ready_o = req_ready_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_err_o   = err_q;
    assign bus.paddr_o     = addr_q;
    assign bus.pwdata_o    = wdata_q;
    assign bus.pwrite_o    = we_q;
    assign bus.psel_o      = psel_q;
    assign bus.penable_o   = penable_q;
endmodule

// File: tb/tb_periph_req2apb_bridge.sv
// tb_periph_req2apb_bridge
// Self-checking bench for periph_req2apb_bridge: directed transfers, randomized
// transfers against a transaction-level expectation, back-to-back requests,
// mid-transfer reset and (when APB_BRIDGE_TIMEOUT_EN is defined) the timeout.
module tb_periph_req2apb_bridge;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   test_cnt = 0;
    int   fail_cnt = 0;

    always #5 clk = ~clk;

    periph_req2apb_bridge_if #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) bus ();

    periph_req2apb_bridge #(
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        test_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Present a request and wait (bounded) for acceptance; returns at the SETUP cycle.
    task automatic send_req(input logic [AW-1:0] addr, input logic we,
                            input logic [DW-1:0] wdata, output bit ok);
        int n;
        bus.req_addr_i  = addr;
        bus.req_we_i    = we;
        bus.req_wdata_i = wdata;
        bus.req_valid_i = 1'b1;
        n = 0;
        while (!bus.req_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = bus.req_ready_o;
        if (!ok) begin
            check("req_ready_wait", 64'(bus.req_ready_o), 64'd1);
            bus.req_valid_i = 1'b0;
            return;
        end
        @(negedge clk);
        // Scramble request inputs: the bridge must work from its own copy.
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = $urandom;
        bus.req_wdata_i = $urandom;
        bus.req_we_i    = 1'($urandom_range(0, 1));
    endtask

    // One full transfer: waits = wait states before pready, rsp_delay = cycles of rsp_ready=0.
    task automatic do_xfer(input logic [AW-1:0] addr, input logic we, input logic [DW-1:0] wdata,
                           input int waits, input logic [DW-1:0] rdata, input logic err,
                           input int rsp_delay);
        bit ok;
        logic [DW-1:0] exp_pw;
        logic [DW-1:0] exp_rd;
        exp_pw = we ? wdata : '0;
        exp_rd = we ? '0 : rdata;
        send_req(addr, we, wdata, ok);
        if (!ok) return;
        check("setup_psel",    64'(bus.psel_o),      64'd1);
        check("setup_penable", 64'(bus.penable_o),   64'd0);
        check("setup_pwrite",  64'(bus.pwrite_o),    64'(we));
        check("setup_paddr",   64'(bus.paddr_o),     64'(addr));
        check("setup_pwdata",  64'(bus.pwdata_o),    64'(exp_pw));
        check("setup_ready",   64'(bus.req_ready_o), 64'd0);
        bus.pready_i  = 1'($urandom_range(0, 1));
        bus.prdata_i  = $urandom;
        bus.pslverr_i = 1'($urandom_range(0, 1));
        @(negedge clk);
        for (int k = 0; k <= waits; k++) begin
            check("access_psel",    64'(bus.psel_o),    64'd1);
            check("access_penable", 64'(bus.penable_o), 64'd1);
            check("access_paddr",   64'(bus.paddr_o),   64'(addr));
            check("access_pwrite",  64'(bus.pwrite_o),  64'(we));
            check("access_pwdata",  64'(bus.pwdata_o),  64'(exp_pw));
            check("access_valid",   64'(bus.rsp_valid_o), 64'd0);
            bus.pready_i  = (k == waits);
            bus.prdata_i  = (k == waits) ? rdata : DW'($urandom);
            bus.pslverr_i = (k == waits) ? err : 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bus.pready_i  = 1'b0;
        bus.prdata_i  = $urandom;
        bus.pslverr_i = 1'($urandom_range(0, 1));
        for (int k = 0; k <= rsp_delay; k++) begin
            bus.rsp_ready_i = (k == rsp_delay);
            check("resp_valid",   64'(bus.rsp_valid_o), 64'd1);
            check("resp_rdata",   64'(bus.rsp_rdata_o), 64'(exp_rd));
            check("resp_err",     64'(bus.rsp_err_o),   64'(err));
            check("resp_psel",    64'(bus.psel_o),      64'd0);
            check("resp_penable", 64'(bus.penable_o),   64'd0);
            check("resp_ready",   64'(bus.req_ready_o), 64'd0);
            @(negedge clk);
        end
        bus.rsp_ready_i = 1'b0;
        check("idle_valid", 64'(bus.rsp_valid_o), 64'd0);
        check("idle_ready", 64'(bus.req_ready_o), 64'd1);
        check("idle_paddr", 64'(bus.paddr_o),     64'(addr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int acc, setups, last, n;
        bit pending;

        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_we_i    = 1'b0;
        bus.req_wdata_i = '0;
        bus.rsp_ready_i = 1'b0;
        bus.prdata_i    = '0;
        bus.pready_i    = 1'b0;
        bus.pslverr_i   = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready_o), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        check("rst_psel",      64'(bus.psel_o),      64'd0);
        check("rst_penable",   64'(bus.penable_o),   64'd0);
        check("rst_paddr",     64'(bus.paddr_o),     64'd0);
        check("rst_pwdata",    64'(bus.pwdata_o),    64'd0);
        check("rst_rdata",     64'(bus.rsp_rdata_o), 64'd0);
        check("rst_err",       64'(bus.rsp_err_o),   64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(bus.req_ready_o), 64'd1);

        // Directed transfers.
        do_xfer(32'h1A10_0000, 1'b1, 32'hDEAD_BEEF, 0, 32'h1234_5678, 1'b0, 0);
        do_xfer(32'h1A10_1004, 1'b0, 32'hFFFF_FFFF, 3, 32'h0000_00A5, 1'b0, 0);
        do_xfer(32'h1A10_2008, 1'b0, 32'h0, 0, 32'hCAFE_F00D, 1'b1, 5);

        // Randomized transfers.
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_xfer($urandom, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3),
                    $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        // Back-to-back: req_valid held, rsp_ready and pready tied high.
        bus.rsp_ready_i = 1'b1;
        bus.pready_i    = 1'b1;
        bus.pslverr_i   = 1'b0;
        bus.req_we_i    = 1'b1;
        bus.req_wdata_i = 32'h5555_0000;
        bus.req_addr_i  = 32'h1A10_3000;
        bus.req_valid_i = 1'b1;
        acc = 0; setups = 0; last = -1; pending = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (pending) begin
                acc++;
                if (acc == 3) bus.req_valid_i = 1'b0;
                else bus.req_addr_i = 32'h1A10_3000 + AW'(acc * 16);
                pending = 1'b0;
            end
            if (bus.psel_o && !bus.penable_o) begin
                check("b2b_paddr", 64'(bus.paddr_o), 64'(32'h1A10_3000 + AW'(setups * 16)));
                if (last >= 0) check("b2b_spacing", 64'(cyc - last), 64'd4);
                last = cyc;
                setups++;
            end
            if (bus.req_ready_o)
                check("b2b_ready_only_idle",
                      64'({bus.psel_o, bus.penable_o, bus.rsp_valid_o}), 64'd0);
            pending = bus.req_valid_i && bus.req_ready_o;
            @(negedge clk);
        end
        check("b2b_setups", 64'(setups), 64'd3);
        bus.rsp_ready_i = 1'b0;
        bus.pready_i    = 1'b0;
        @(negedge clk);

        // Reset during ACCESS abandons the transfer.
        send_req(32'h1A10_4000, 1'b0, 32'h0, ok);
        @(negedge clk);
        @(negedge clk);
        check("mid_penable", 64'(bus.penable_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_psel",      64'(bus.psel_o),      64'd0);
        check("arst_penable",   64'(bus.penable_o),   64'd0);
        check("arst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        check("arst_req_ready", 64'(bus.req_ready_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("arst_idle_ready", 64'(bus.req_ready_o), 64'd1);
            check("arst_no_rsp",     64'(bus.rsp_valid_o), 64'd0);
            check("arst_no_psel",    64'(bus.psel_o),      64'd0);
            @(negedge clk);
        end

`ifdef APB_BRIDGE_TIMEOUT_EN
        // pready never arrives: ACCESS lasts TO+1 cycles, then error response.
        send_req(32'h1A10_5000, 1'b0, 32'h0, ok);
        @(negedge clk);
        bus.prdata_i = 32'h7777_7777;
        n = 0;
        while (bus.penable_o && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("to_access_cycles", 64'(n), 64'(TO + 1));
        check("to_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
        check("to_rsp_err",   64'(bus.rsp_err_o),   64'd1);
        check("to_rsp_rdata", 64'(bus.rsp_rdata_o), 64'd0);
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        // pready on the limit cycle wins.
        do_xfer(32'h1A10_6000, 1'b0, 32'h0, TO, 32'h0BAD_CAFE, 1'b0, 0);
`else
        n = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end
endmodule

// File: doc/periph_req2apb_bridge.md
Name: periph_req2apb_bridge

Overview:
Upstream stage of the peripheral APB bus wrapper and its address-decoding node. Converts a single-outstanding valid/ready request from the SoC interconnect side into one APB3 transfer: SETUP phase, then ACCESS phase. Returns read data and error status on a valid/ready response channel. Drives the slave port of the peripheral bus wrapper, which decodes the address to UART, GPIO, SPI, timer, VGA and the other peripherals.

Parameters:
APB_ADDR_WIDTH, 32, width of request address and PADDR
APB_DATA_WIDTH, 32, width of write/read data and PWDATA/PRDATA
TIMEOUT_CYCLES, 255, ACCESS-phase wait limit; used only with the optional feature

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when high together with req_valid_i
req_addr_i  in  APB_ADDR_WIDTH  byte address
req_we_i  in  1  1 = write, 0 = read
req_wdata_i  in  APB_DATA_WIDTH  write data
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed
rsp_rdata_o  out  APB_DATA_WIDTH  read data; 0 for writes
rsp_err_o  out  1  PSLVERR, or timeout error
paddr_o  out  APB_ADDR_WIDTH  APB address
pwdata_o  out  APB_DATA_WIDTH  APB write data
pwrite_o  out  1  APB direction
psel_o  out  1  APB select
penable_o  out  1  APB enable
prdata_i  in  APB_DATA_WIDTH  APB read data
pready_i  in  1  APB ready
pslverr_i  in  1  APB slave error

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: all outputs 0 (req_ready_o 0 while in reset). FSM returns to IDLE asynchronously; any in-flight transfer is abandoned with no response.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch addr, we and wdata; clear wdata to 0 for reads. Go to SETUP.
- SETUP:
  - psel_o=1, penable_o=0; paddr/pwrite/pwdata driven from the latched registers.
  - pready_i is ignored. Unconditionally go to ACCESS.
- ACCESS:
  - psel_o=1, penable_o=1.
  - While pready_i=0, stay.
  - On pready_i=1:
    - Read: latch prdata_i into rsp_rdata_o. Write: set rsp_rdata_o=0.
    - Latch pslverr_i into rsp_err_o.
    - Go to RESP. psel/penable drop to 0 in the next cycle.
- RESP:
  - rsp_valid_o=1; rsp_rdata_o and rsp_err_o held stable.
  - On rsp_ready_i=1, go to IDLE and clear rsp_valid_o.
- Handshake rules:
  - req_ready_o=0 in every state except IDLE. At most one transfer is outstanding.
  - A new request accepted in cycle N drives SETUP in N+1.
- Stability: paddr_o, pwrite_o and pwdata_o are constant from SETUP through the last ACCESS cycle. They keep their last value while in IDLE and RESP (no toggling).
- Latency: accept at cycle N, SETUP N+1, ACCESS N+2. With zero-wait pready, rsp_valid_o is high at N+3.
- Back-to-back: response consumed at cycle M puts the FSM in IDLE at M+1; the next accept is at M+1 at the earliest.
- Address: passed through unmodified (no alignment forcing). The decoding node handles unmapped addresses.

Optional Feature:
- Macro: APB_BRIDGE_TIMEOUT_EN.
- Defined:
  - Counter of width clog2(TIMEOUT_CYCLES+1). Cleared on entry to ACCESS; increments each ACCESS cycle with pready_i=0.
  - When the count equals TIMEOUT_CYCLES and pready_i is still 0, the transfer ends: go to RESP with rsp_err_o=1 and rsp_rdata_o=0.
  - pready_i=1 in the same cycle as the limit wins: normal completion.
- Not defined: no counter logic; ACCESS waits indefinitely for pready_i.

Test Plan:
- Write 0x1A10_0000 data 0xDEAD_BEEF, pready tied 1 -> SETUP at N+1 with psel=1, penable=0, pwrite=1; ACCESS at N+2; rsp_valid at N+3 with rsp_rdata=0, rsp_err=0.
- Read 0x1A10_1004, slave inserts 3 wait states then prdata=0x0000_00A5 -> penable high for 4 cycles, paddr stable throughout; rsp_rdata=0xA5 one cycle after pready.
- Read with pslverr=1 on the pready cycle -> rsp_err=1; rsp_valid held over 5 cycles of rsp_ready=0, data stable; IDLE one cycle after rsp_ready=1.
- req_valid held high continuously for 3 requests, rsp_ready tied 1 -> req_ready pulses only in IDLE; exactly 3 SETUP phases, each 4 cycles apart.
- rst_ni asserted mid-ACCESS -> psel, penable, rsp_valid and req_ready go to 0 immediately; after release, IDLE with req_ready=1 and no spurious response.
- With APB_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=4, pready held 0 -> ACCESS lasts 5 cycles, then rsp_err=1, rsp_rdata=0. Repeat with pready=1 on the limit cycle -> normal response, rsp_err=0.
